// File: rtl/dispatch_ctrl.sv
// Dispatch controller: gates instruction allocation on resource availability, serialises CSR
// instructions behind an empty ROB, and sequences front-end flush/recovery after a mispredict.
module dispatch_ctrl #(
   parameter int RECOVER_CYC = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dc_valid,
   input  logic             dc_is_load,
   input  logic             dc_is_store,
   input  logic             dc_is_csr,
   input  logic             rob_ready,
   input  logic             rob_empty,
   input  logic             lq_ready,
   input  logic             sq_ready,
   input  logic             is_ready,
   input  logic             mispredict,
   input  logic             csr_commit,
   input  logic             perf_clr,
   output logic             dc_ready,
   output logic             dispatch_fire,
   output logic             flush_front,
   output logic [2:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [2:0] ST_RUN     = 3'd0;
   localparam logic [2:0] ST_DRAIN   = 3'd1;
   localparam logic [2:0] ST_SERIAL  = 3'd2;
   localparam logic [2:0] ST_FLUSH   = 3'd3;
   localparam logic [2:0] ST_RECOVER = 3'd4;

   localparam logic [3:0] REC_LOAD = 4'(RECOVER_CYC - 1);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [3:0] rec_cnt;
   logic [3:0] rec_cnt_nxt;
   logic       res_ok;

   // Handshake: an instruction is allocated in exactly the cycle dc_valid and dc_ready are both
   // high; dc_ready never depends on dc_valid, so decode may hold or drop its offer freely.
   assign res_ok = rob_ready & is_ready & (!dc_is_load | lq_ready) & (!dc_is_store | sq_ready);

   always_comb begin
      dc_ready = 1'b0;
      if (!mispredict && res_ok) begin
         if (state == ST_RUN)
            dc_ready = !dc_is_csr | rob_empty;
         else if (state == ST_DRAIN)
            dc_ready = rob_empty;
      end
   end

   assign dispatch_fire = dc_valid & dc_ready;
   assign flush_front   = (state == ST_FLUSH);
   assign ctrl_state    = state;

   always_comb begin
      state_nxt   = state;
      rec_cnt_nxt = rec_cnt;
      if (mispredict) begin
         state_nxt = ST_FLUSH;
      end else begin
         case (state)
            ST_RUN: begin
               if (dispatch_fire && dc_is_csr)
                  state_nxt = ST_SERIAL;
               else if (dc_valid && dc_is_csr)
                  state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (dispatch_fire)
                  state_nxt = dc_is_csr ? ST_SERIAL : ST_RUN;
               else if (!dc_valid)
                  state_nxt = ST_RUN;
            end
            ST_SERIAL: begin
               if (csr_commit)
                  state_nxt = ST_RUN;
            end
            ST_FLUSH: begin
               state_nxt   = ST_RECOVER;
               rec_cnt_nxt = REC_LOAD;
            end
            ST_RECOVER: begin
               if (rec_cnt == 4'd0)
                  state_nxt = ST_RUN;
               else
                  rec_cnt_nxt = rec_cnt - 4'd1;
            end
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_RUN;
         rec_cnt <= 4'd0;
      end else begin
         state   <= state_nxt;
         rec_cnt <= rec_cnt_nxt;
      end
   end

   // Counter saturates at all-ones; a clear in the same cycle as a stall wins.
   always_ff @(posedge clk) begin
      if (rst || perf_clr)
         stall_cnt <= '0;
      else if (dc_valid && !dispatch_fire && !(&stall_cnt))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 SHALL have parameter RECOVER_CYC, default 2, meaning stall cycles after a flush; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall performance counter.
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port dc_valid  in  1  decoded instruction present at dispatch.
REQ-006 SHALL have ports dc_is_load, dc_is_store, dc_is_csr  in  1 each  instruction class flags from decode.
REQ-007 SHALL have ports rob_ready, rob_empty, lq_ready, sq_ready, is_ready  in  1 each  downstream resource status.
REQ-008 SHALL have port mispredict  in  1  branch mispredict / flush request.
REQ-009 SHALL have port csr_commit  in  1  in-flight CSR instruction retired.
REQ-010 SHALL have port perf_clr  in  1  synchronous clear of the stall counter.
REQ-011 SHALL have port dc_ready  out  1  dispatch would be accepted this cycle, independent of dc_valid.
REQ-012 SHALL have port dispatch_fire  out  1  instruction allocated into ROB/LSU/IQ this cycle.
REQ-013 SHALL have port flush_front  out  1  clear front-end and decode pipeline registers.
REQ-014 SHALL have port ctrl_state  out  3  current FSM state encoding.
REQ-015 SHALL have port stall_cnt  out  CNT_W  saturating count of blocked dispatch cycles.

Function
REQ-016 SHALL implement FSM states RUN=0, DRAIN=1, SERIAL=2, FLUSH=3, RECOVER=4; ctrl_state equals the registered state.
REQ-017 SHALL compute res_ok = rob_ready & is_ready & (!dc_is_load | lq_ready) & (!dc_is_store | sq_ready).
REQ-018 SHALL drive dc_ready = !mispredict & res_ok & (state==RUN & !dc_is_csr | state==RUN & dc_is_csr & rob_empty | state==DRAIN & rob_empty); 0 in SERIAL, FLUSH, RECOVER.
REQ-019 SHALL drive dispatch_fire = dc_valid & dc_ready, combinationally, same cycle.
REQ-020 RUN: non-CSR fire -> stay RUN; CSR fire (rob_empty & res_ok) -> SERIAL; dc_valid & dc_is_csr & !dispatch_fire -> DRAIN.
REQ-021 DRAIN: CSR fire -> SERIAL; dc_valid low -> RUN; otherwise hold DRAIN.
REQ-022 SERIAL: no dispatch; csr_commit -> RUN next cycle; no dispatch in the cycle csr_commit is high.
REQ-023 FLUSH: flush_front=1 for exactly one cycle; load recovery counter with RECOVER_CYC-1; -> RECOVER.
REQ-024 RECOVER: decrement counter each cycle; at counter==0 -> RUN next cycle, giving exactly RECOVER_CYC cycles in RECOVER.
REQ-025 mispredict high in any state SHALL force dispatch_fire=0 that cycle and next state FLUSH, with priority over csr_commit and all other transitions.
REQ-026 mispredict during FLUSH or RECOVER SHALL restart at FLUSH with a full recovery count.
REQ-027 flush_front SHALL be asserted only while state==FLUSH.
REQ-028 stall_cnt SHALL increment by 1 when dc_valid & !dispatch_fire, hold at all-ones on saturation, and reset to 0 on perf_clr; perf_clr wins over increment.
REQ-029 csr_commit outside SERIAL SHALL be ignored.

Reset
REQ-030 On rst: state=RUN, recovery counter=0, stall_cnt=0; flush_front=0; dispatch_fire and dc_ready follow REQ-018/019 with state RUN.
REQ-031 rst asserted mid-DRAIN, SERIAL or RECOVER SHALL return to RUN on the next edge with no flush_front pulse.

Verification
REQ-032 Steady flow: dc_valid=1, non-CSR, all resources ready for 5 cycles -> dispatch_fire=1 each cycle, state stays 0, stall_cnt=0.
REQ-033 CSR serialization: CSR with rob_empty=0 for 3 cycles then 1 -> state 1 for 3 cycles, fire on the 4th, state 2; csr_commit 6 cycles later -> state 0; stall_cnt=3 plus any dc_valid cycles in SERIAL.
REQ-034 Mispredict: mispredict pulse in RUN -> next cycle state 3 with flush_front=1, then state 4 for 2 cycles, then state 0; dispatch_fire=0 throughout.
REQ-035 Re-flush: second mispredict during RECOVER, first cycle -> FLUSH again, then a full 2-cycle RECOVER.
REQ-036 Resource block: load with lq_ready=0 -> dc_ready=0, stall_cnt increments per cycle; lq_ready=1 -> fire; with CNT_W=4, 20 blocked cycles -> stall_cnt=15; perf_clr -> 0.
REQ-037 Priority: mispredict and csr_commit in the same cycle while in SERIAL -> next state FLUSH, not RUN.
